bus_arb_master_mux: RTL and testbench
=====================================

BUS_ARB_MASTER_MUX -- requirements
Module: bus_arb_master_mux

Interface
REQ-001 Parameters SHALL be N_MST, default 4, master count (2..8); ADDR_W, default 30, word-address width; DATA_W, default 32, write-data width; MAX_HOLD, default 16, maximum tenure cycles under contention (0 = unlimited); REG_OUT, default 1, 1 = registered slave outputs, 0 = combinational.
REQ-002 Port clk, input, 1, sole clock; all state changes on rising edge.
REQ-003 Port reset_, input, 1; reset is synchronous and active-low.
REQ-004 Port m_req_, input, N_MST; per-master bus request, active-low.
REQ-005 Port m_addr, input, N_MST*ADDR_W; master i at bits [i*ADDR_W +: ADDR_W].
REQ-006 Ports m_as_ (active-low) and m_rw (1=READ), input, N_MST each; address strobe and direction per master.
REQ-007 Port m_wr_data, input, N_MST*DATA_W; packed as m_addr.
REQ-008 Port m_grnt_, output, N_MST; one-cold grant, registered.
REQ-009 Ports s_addr (ADDR_W), s_as_ (1), s_rw (1), s_wr_data (DATA_W), output; slave-side bus.
REQ-010 Port owner_idx, output, $clog2(N_MST); current owner index, valid only when bus_busy=1.
REQ-011 Port bus_busy, output, 1; 1 while any grant active.

Function
REQ-012 FSM SHALL have two states: IDLE (no grant) and OWNED (exactly one grant).
REQ-013 IDLE -> OWNED on the edge after any m_req_ bit is 0; winner = first requester found searching from index ptr upward, modulo N_MST.
REQ-014 Request-to-grant latency SHALL be 1 cycle: m_req_[i]=0 sampled at edge t gives m_grnt_[i]=0 after edge t.
REQ-015 In OWNED, the owner keeps the grant while its m_req_ is 0, subject to REQ-017.
REQ-016 Owner releases (m_req_ = 1) and another master requests: grant SHALL pass directly to the next round-robin winner on the same edge, with no idle cycle; with no other requester, OWNED -> IDLE.
REQ-017 hold_cnt SHALL clear on every new grant and increment each OWNED cycle, saturating at MAX_HOLD. When hold_cnt = MAX_HOLD-1, MAX_HOLD≠0 and another master requests, the grant SHALL move to the next winner on that edge.
REQ-018 Without contention the owner SHALL keep the grant indefinitely; the counter saturates.
REQ-019 On every grant to master k, ptr SHALL become (k+1) mod N_MST; the wrap from N_MST-1 to 0 SHALL be exact.
REQ-020 If several masters request at once, only the round-robin winner is granted; m_grnt_ SHALL never have more than one 0 bit.
REQ-021 With REG_OUT=1, s_* at cycle t+1 SHALL equal the owner's m_* at cycle t (1-cycle latency); with REG_OUT=0, s_* SHALL follow the owner's m_* in the same cycle.
REQ-022 When no grant is active: s_as_=1, s_rw=1 (READ), s_addr=0, s_wr_data=0.
REQ-023 On a grant switch, s_as_ SHALL come only from the new owner from the first granted cycle; no strobe from the previous owner may leak.
REQ-024 If a master drops m_req_ while not granted, it SHALL NOT be granted.

Reset
REQ-025 While reset_=0 at an edge: state=IDLE, m_grnt_ all 1, ptr=0, hold_cnt=0, owner_idx=0, bus_busy=0, s_* = REQ-022 values.
REQ-026 Reset asserted mid-tenure SHALL revoke the grant on that edge; after release, master 0 has top priority.

Structure
REQ-027 Shared bus definitions package SHALL hold ENABLE_/DISABLE_, READ/WRITE, and default ADDR_W/DATA_W constants; this module defines no new global macros.
REQ-028 One sub-module bus_rr_pick SHALL be used: combinational, N_MST-wide request vector plus ptr in, winner index plus valid out.

Verification
REQ-029 Single request: N_MST=4, m_req_=4'b1101 from cycle 2 -> m_grnt_=4'b1101 from cycle 3, bus_busy=1, owner_idx=1.
REQ-030 Round robin: all four request continuously with MAX_HOLD=4 -> grant order 0,1,2,3,0; each tenure exactly 4 cycles, no gap.
REQ-031 Direct handoff: master 2 owns, master 0 requests, master 2 releases at cycle 10 -> m_grnt_=4'b1110 after edge 10, no IDLE cycle, s_as_ from master 0 only.
REQ-032 No contention: MAX_HOLD=4, master 3 sole requester for 50 cycles -> grant held all 50 cycles, hold_cnt saturates at 4.
REQ-033 Reset mid-tenure: reset_=0 for 1 cycle while master 1 owns -> m_grnt_=4'hF, s_as_=1 next cycle; simultaneous requests from 1 and 0 then grant master 0 first.
REQ-034 REG_OUT=1 datapath: owner drives m_addr=30'h0000_1234, m_wr_data=32'hDEAD_BEEF, m_rw=0 at cycle t -> exactly those values on s_* at cycle t+1.

Source files
------------

// File: rtl/bus_arb_master_mux_pkg.sv
// bus_arb_master_mux_pkg: shared bus polarity constants, default widths and arbiter state type
package bus_arb_master_mux_pkg;
    localparam logic ENABLE_    = 1'b0;
    localparam logic DISABLE_   = 1'b1;
    localparam logic READ       = 1'b1;
    localparam logic WRITE      = 1'b0;
    localparam int   DEF_ADDR_W = 30;
    localparam int   DEF_DATA_W = 32;
    typedef enum logic {IDLE, OWNED} arb_state_e;
endpackage

// File: rtl/bus_arb_master_mux_rr_pick.sv
// bus_rr_pick: combinational round-robin pick of the first active request at or above ptr
module bus_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);
    logic [N-1:0] w_rot;
    logic [IW:0]  w_sum;
    assign w_rot = N'({i_req, i_req} >> i_ptr);
    // scan downward so the lowest rotated offset is the last one written and wins
    always_comb begin
        o_idx   = '0;
        o_valid = |w_rot;
        w_sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + (IW + 1)'(k);
                o_idx = (w_sum >= (IW + 1)'(N)) ? IW'(w_sum - (IW + 1)'(N)) : IW'(w_sum);
            end
        end
    end
endmodule

// File: rtl/bus_arb_master_mux.sv
// bus_arb_master_mux: round-robin bus arbiter with hold limit and master-to-slave bus mux
module bus_arb_master_mux
    import bus_arb_master_mux_pkg::*;
#(
    parameter int N_MST    = 4,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = 16,
    parameter int REG_OUT  = 1
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic [N_MST-1:0]           m_req_,
    input  logic [N_MST*ADDR_W-1:0]    m_addr,
    input  logic [N_MST-1:0]           m_as_,
    input  logic [N_MST-1:0]           m_rw,
    input  logic [N_MST*DATA_W-1:0]    m_wr_data,
    output logic [N_MST-1:0]           m_grnt_,
    output logic [ADDR_W-1:0]          s_addr,
    output logic                       s_as_,
    output logic                       s_rw,
    output logic [DATA_W-1:0]          s_wr_data,
    output logic [$clog2(N_MST)-1:0]   owner_idx,
    output logic                       bus_busy
);
    localparam int IW = $clog2(N_MST);
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

    arb_state_e        r_state, w_state;
    logic [IW-1:0]     r_owner, w_owner, r_ptr, w_ptr, w_pick_idx, w_sel_owner;
    logic [HW-1:0]     r_hold, w_hold;
    logic [N_MST-1:0]  r_grnt_, w_req, w_pick_req;
    logic              w_pick_vld, w_expire, w_take, w_drop, w_sel_act;
    logic [ADDR_W-1:0] w_addr_a [N_MST];
    logic [DATA_W-1:0] w_data_a [N_MST];

    assign w_req      = ~m_req_;
    assign w_pick_req = (r_state == OWNED) ? (w_req & ~(N_MST'(1) << r_owner)) : w_req;
    assign w_expire   = (MAX_HOLD != 0) && (r_hold >= HOLD_LAST);

    bus_rr_pick #(.N(N_MST), .IW(IW)) u_pick (
        .i_req   (w_pick_req),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_vld)
    );

    // next state: grant on idle, handoff on release, forced move on expired tenure under contention
    always_comb begin
        w_take  = w_pick_vld && (r_state == IDLE || !w_req[r_owner] || w_expire);
        w_drop  = (r_state == OWNED) && !w_req[r_owner] && !w_pick_vld;
        w_state = w_take ? OWNED : (w_drop ? IDLE : r_state);
        w_owner = w_take ? w_pick_idx : r_owner;
        w_ptr   = w_take ? ((w_pick_idx == IW'(N_MST - 1)) ? '0 : w_pick_idx + 1'b1) : r_ptr;
        w_hold  = (w_take || w_state == IDLE) ? '0 : ((r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1);
    end

    // arbiter state registers with one-cold grant decoded from the next owner
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_grnt_ <= '1;
        end else begin
            r_state <= w_state;
            r_owner <= w_owner;
            r_ptr   <= w_ptr;
            r_hold  <= w_hold;
            r_grnt_ <= (w_state == OWNED) ? ~(N_MST'(1) << w_owner) : '1;
        end
    end

    assign m_grnt_   = r_grnt_;
    assign owner_idx = r_owner;
    assign bus_busy  = (r_state == OWNED);

    for (genvar g = 0; g < N_MST; g++) begin : g_unpack
        assign w_addr_a[g] = m_addr[g*ADDR_W +: ADDR_W];
        assign w_data_a[g] = m_wr_data[g*DATA_W +: DATA_W];
    end

    // registered outputs sample the upcoming owner so a new owner's strobe shows on its first granted cycle
    assign w_sel_owner = (REG_OUT != 0) ? w_owner : r_owner;
    assign w_sel_act   = (REG_OUT != 0) ? (w_state == OWNED) : (r_state == OWNED);

    if (REG_OUT != 0) begin : g_reg
        // slave bus registers, parked at idle values when no grant is active
        always_ff @(posedge clk) begin
            if (!reset_) begin
                s_addr    <= '0;
                s_as_     <= DISABLE_;
                s_rw      <= READ;
                s_wr_data <= '0;
            end else begin
                s_addr    <= w_sel_act ? w_addr_a[w_sel_owner] : '0;
                s_as_     <= w_sel_act ? m_as_[w_sel_owner] : DISABLE_;
                s_rw      <= w_sel_act ? m_rw[w_sel_owner] : READ;
                s_wr_data <= w_sel_act ? w_data_a[w_sel_owner] : '0;
            end
        end
    end else begin : g_comb
        assign s_addr    = w_sel_act ? w_addr_a[w_sel_owner] : '0;
        assign s_as_     = w_sel_act ? m_as_[w_sel_owner] : DISABLE_;
        assign s_rw      = w_sel_act ? m_rw[w_sel_owner] : READ;
        assign s_wr_data = w_sel_act ? w_data_a[w_sel_owner] : '0;
    end
endmodule

// File: tb/tb_bus_arb_master_mux.sv
// tb_bus_arb_master_mux: table-driven scoreboard bench for the round-robin bus arbiter
module tb_bus_arb_master_mux;
    logic         clk = 1'b0;
    logic         reset_;
    logic [3:0]   m_req_, m_as_, m_rw, m_grnt_;
    logic [119:0] m_addr;
    logic [127:0] m_wr_data;
    logic [29:0]  s_addr;
    logic         s_as_, s_rw, bus_busy;
    logic [31:0]  s_wr_data;
    logic [1:0]   owner_idx;
    int           n_pass = 0;
    int           n_tot  = 0;

    typedef struct packed {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] as_;
        logic [3:0] grnt;
        logic       busy;
        logic [1:0] own;
        logic       sas;
    } vec_t;

    vec_t tbl [28];
    vec_t sb [$];

    bus_arb_master_mux #(.N_MST(4), .ADDR_W(30), .DATA_W(32), .MAX_HOLD(4), .REG_OUT(1)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .m_req_    (m_req_),
        .m_addr    (m_addr),
        .m_as_     (m_as_),
        .m_rw      (m_rw),
        .m_wr_data (m_wr_data),
        .m_grnt_   (m_grnt_),
        .s_addr    (s_addr),
        .s_as_     (s_as_),
        .s_rw      (s_rw),
        .s_wr_data (s_wr_data),
        .owner_idx (owner_idx),
        .bus_busy  (bus_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic set_defaults();
        for (int i = 0; i < 4; i++) begin
            m_addr[i*30 +: 30]    = 30'h100 + 30'(i);
            m_wr_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
            m_rw[i]               = i[0];
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        reset_ = v.rst_n;
        m_req_ = v.req;
        m_as_  = v.as_;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("grnt", 64'(m_grnt_), 64'(e.grnt));
        chk("onecold", 64'($countones(~m_grnt_) <= 1), 64'(1));
        chk("busy", 64'(bus_busy), 64'(e.busy));
        if (e.busy) chk("owner", 64'(owner_idx), 64'(e.own));
        chk("s_as_", 64'(s_as_), 64'(e.sas));
        chk("s_addr", 64'(s_addr), e.busy ? 64'(30'h100 + 30'(e.own)) : 64'(0));
        chk("s_rw", 64'(s_rw), e.busy ? 64'(e.own[0]) : 64'(1));
        chk("s_wr_data", 64'(s_wr_data), e.busy ? 64'(32'hA000_0000 + 32'(e.own)) : 64'(0));
    endtask

    initial begin
        set_defaults();
        reset_ = 1'b0;
        m_req_ = 4'hF;
        m_as_  = 4'hF;
        tbl[0]  = '{1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b0, 2'd0, 1'b1};
        tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b0, 2'd0, 1'b1};
        tbl[2]  = '{1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b0, 2'd0, 1'b1};
        tbl[3]  = '{1'b1, 4'b1101, 4'b1101, 4'b1101, 1'b1, 2'd1, 1'b0};
        tbl[4]  = '{1'b1, 4'b1101, 4'b1101, 4'b1101, 1'b1, 2'd1, 1'b0};
        tbl[5]  = '{1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b0, 2'd0, 1'b1};
        tbl[6]  = '{1'b1, 4'b0000, 4'b1111, 4'b1011, 1'b1, 2'd2, 1'b1};
        tbl[7]  = '{1'b1, 4'b0000, 4'b1111, 4'b1011, 1'b1, 2'd2, 1'b1};
        tbl[8]  = '{1'b1, 4'b0000, 4'b1111, 4'b1011, 1'b1, 2'd2, 1'b1};
        tbl[9]  = '{1'b1, 4'b0000, 4'b1111, 4'b1011, 1'b1, 2'd2, 1'b1};
        tbl[10] = '{1'b1, 4'b0000, 4'b1111, 4'b0111, 1'b1, 2'd3, 1'b1};
        tbl[11] = '{1'b1, 4'b0000, 4'b1111, 4'b0111, 1'b1, 2'd3, 1'b1};
        tbl[12] = '{1'b1, 4'b0000, 4'b1111, 4'b0111, 1'b1, 2'd3, 1'b1};
        tbl[13] = '{1'b1, 4'b0000, 4'b1111, 4'b0111, 1'b1, 2'd3, 1'b1};
        tbl[14] = '{1'b1, 4'b0000, 4'b1111, 4'b1110, 1'b1, 2'd0, 1'b1};
        tbl[15] = '{1'b1, 4'b0000, 4'b1111, 4'b1110, 1'b1, 2'd0, 1'b1};
        tbl[16] = '{1'b1, 4'b0000, 4'b1111, 4'b1110, 1'b1, 2'd0, 1'b1};
        tbl[17] = '{1'b1, 4'b0000, 4'b1111, 4'b1110, 1'b1, 2'd0, 1'b1};
        tbl[18] = '{1'b1, 4'b0000, 4'b1111, 4'b1101, 1'b1, 2'd1, 1'b1};
        tbl[19] = '{1'b1, 4'b1110, 4'b1101, 4'b1110, 1'b1, 2'd0, 1'b1};
        tbl[20] = '{1'b1, 4'b1110, 4'b1110, 4'b1110, 1'b1, 2'd0, 1'b0};
        tbl[21] = '{1'b1, 4'b1010, 4'b1110, 4'b1110, 1'b1, 2'd0, 1'b0};
        tbl[22] = '{1'b1, 4'b1110, 4'b1110, 4'b1110, 1'b1, 2'd0, 1'b0};
        tbl[23] = '{1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b0, 2'd0, 1'b1};
        tbl[24] = '{1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b0, 2'd0, 1'b1};
        tbl[25] = '{1'b1, 4'b1101, 4'b1101, 4'b1101, 1'b1, 2'd1, 1'b0};
        tbl[26] = '{1'b0, 4'b1100, 4'b1111, 4'b1111, 1'b0, 2'd0, 1'b1};
        tbl[27] = '{1'b1, 4'b1100, 4'b1100, 4'b1110, 1'b1, 2'd0, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 28; i++) step(tbl[i]);
        step('{1'b1, 4'b0111, 4'b0111, 4'b0111, 1'b1, 2'd3, 1'b0});
        for (int i = 0; i < 50; i++) step('{1'b1, 4'b0111, 4'b0111, 4'b0111, 1'b1, 2'd3, 1'b0});
        m_addr[3*30 +: 30]    = 30'h0000_1234;
        m_wr_data[3*32 +: 32] = 32'hDEAD_BEEF;
        m_rw[3]               = 1'b0;
        chk("dp_pre_addr", 64'(s_addr), 64'(30'h103));
        @(posedge clk);
        #1;
        chk("dp_addr", 64'(s_addr), 64'(30'h0000_1234));
        chk("dp_wr_data", 64'(s_wr_data), 64'(32'hDEAD_BEEF));
        chk("dp_rw", 64'(s_rw), 64'(0));
        chk("dp_as_", 64'(s_as_), 64'(0));
        set_defaults();
        @(posedge clk);
        #1;
        chk("dp_restore_addr", 64'(s_addr), 64'(30'h103));
        step('{1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b0, 2'd0, 1'b1});
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
